// File: rtl/shadow_assign_table_if.sv
// Bus bundle for shadow_assign_table: resync/live update inputs, query port and status outputs.
interface shadow_assign_table_if #(
   parameter int unsigned NUM_VARS = 1024,
   parameter int unsigned CNT_W    = $clog2(NUM_VARS) + 1
);
   logic             clear_shadows;
   logic             resync_valid;
   logic [31:0]      resync_var;
   logic             resync_value;
   logic             resync_done;
   logic [15:0]      trail_height;
   logic             assign_valid;
   logic [31:0]      assign_var;
   logic             assign_value;
   logic             unassign_valid;
   logic [31:0]      unassign_var;
   logic             query_valid;
   logic [31:0]      query_var;
   logic             query_rsp_valid;
   logic             query_rsp_assigned;
   logic             query_rsp_value;
   logic [CNT_W-1:0] assigned_count;
   logic             syncing;
   logic             sync_ok;
   logic             sync_err;
   logic             err_range;
   logic             err_conflict;

   modport master (
      output clear_shadows, resync_valid, resync_var, resync_value, resync_done, trail_height,
             assign_valid, assign_var, assign_value, unassign_valid, unassign_var,
             query_valid, query_var,
      input  query_rsp_valid, query_rsp_assigned, query_rsp_value, assigned_count,
             syncing, sync_ok, sync_err, err_range, err_conflict
   );

   modport slave (
      input  clear_shadows, resync_valid, resync_var, resync_value, resync_done, trail_height,
             assign_valid, assign_var, assign_value, unassign_valid, unassign_var,
             query_valid, query_var,
      output query_rsp_valid, query_rsp_assigned, query_rsp_value, assigned_count,
             syncing, sync_ok, sync_err, err_range, err_conflict
   );
endinterface

// File: rtl/shadow_assign_table.sv
// Per-variable shadow assignment store rebuilt by trail resync and updated live by the PSE.
// Optional macro SHADOW_CHECK_EN enables range/conflict detection and the err_* flags.
module shadow_assign_table #(
   parameter int unsigned NUM_VARS = 1024
) (
   input logic                  clk,
   input logic                  rst_n,
   shadow_assign_table_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(NUM_VARS) + 1;
   localparam int unsigned IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

   typedef enum logic [1:0] {ST_READY, ST_SYNC, ST_CHECK} state_e;

   state_e              state_q, state_d;
   logic [NUM_VARS-1:0] valid_q, valid_d, value_q, value_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [15:0]         th_q, th_d;
   logic                syncing_q, sync_ok_q, sync_ok_d, sync_err_q, sync_err_d;
   logic                rsp_valid_q, rsp_assigned_q, rsp_value_q;

   logic             r_in, a_in, u_in, q_in;
   logic [IDX_W-1:0] r_idx, a_idx, u_idx, q_idx;
   logic             clr, ready, a_ok, r_we, a_we, u_we;
   logic             r_inc, a_inc, u_dec, err_any, cnt_match;

   // Full 32-bit range compare so high index bits never alias into the table
   assign r_in  = bus.resync_var   < 32'(NUM_VARS);
   assign a_in  = bus.assign_var   < 32'(NUM_VARS);
   assign u_in  = bus.unassign_var < 32'(NUM_VARS);
   assign q_in  = bus.query_var    < 32'(NUM_VARS);
   assign r_idx = IDX_W'(bus.resync_var);
   assign a_idx = IDX_W'(bus.assign_var);
   assign u_idx = IDX_W'(bus.unassign_var);
   assign q_idx = IDX_W'(bus.query_var);

   // Priority clear > resync > assign > unassign; losers on a shared index are dropped
   assign clr   = bus.clear_shadows;
   assign ready = (state_q == ST_READY);
   assign a_ok  = bus.assign_valid && ready && !clr;
   assign r_we  = bus.resync_valid && !clr && r_in;
   assign a_we  = a_ok && a_in && !(r_we && (r_idx == a_idx));
   assign u_we  = bus.unassign_valid && ready && !clr && u_in
                  && !(r_we && (r_idx == u_idx))
                  && !(a_ok && a_in && (a_idx == u_idx));

   assign r_inc = r_we && !valid_q[r_idx];
   assign a_inc = a_we && !valid_q[a_idx];
   assign u_dec = u_we &&  valid_q[u_idx];

   assign cnt_match = (32'(cnt_q) == 32'(th_q));

   // Surviving writes hit distinct indices, so application order is irrelevant
   always_comb begin
      valid_d = valid_q;
      value_d = value_q;
      cnt_d   = cnt_q + CNT_W'(r_inc) + CNT_W'(a_inc) - CNT_W'(u_dec);
      if (u_we) valid_d[u_idx] = 1'b0;
      if (a_we) begin
         valid_d[a_idx] = 1'b1;
         value_d[a_idx] = bus.assign_value;
      end
      if (r_we) begin
         valid_d[r_idx] = 1'b1;
         value_d[r_idx] = bus.resync_value;
      end
      if (clr) begin
         valid_d = '0;
         cnt_d   = '0;
      end
   end

   always_comb begin
      state_d    = state_q;
      th_d       = th_q;
      sync_ok_d  = 1'b0;
      sync_err_d = 1'b0;
      unique case (state_q)
         ST_READY: if (clr) state_d = ST_SYNC;
         ST_SYNC: begin
            if (clr) begin
               state_d = ST_SYNC;
            end else if (bus.resync_done) begin
               state_d = ST_CHECK;
               th_d    = bus.trail_height;
            end
         end
         ST_CHECK: begin
            if (clr) begin
               state_d = ST_SYNC;
            end else begin
               state_d    = ST_READY;
               sync_ok_d  = cnt_match && !err_any;
               sync_err_d = !(cnt_match && !err_any);
            end
         end
         default: state_d = ST_READY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_READY;
         valid_q        <= '0;
         value_q        <= '0;
         cnt_q          <= '0;
         th_q           <= '0;
         syncing_q      <= 1'b0;
         sync_ok_q      <= 1'b0;
         sync_err_q     <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_assigned_q <= 1'b0;
         rsp_value_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         valid_q        <= valid_d;
         value_q        <= value_d;
         cnt_q          <= cnt_d;
         th_q           <= th_d;
         syncing_q      <= (state_d != ST_READY);
         sync_ok_q      <= sync_ok_d;
         sync_err_q     <= sync_err_d;
         rsp_valid_q    <= bus.query_valid;
         rsp_assigned_q <= bus.query_valid && q_in && valid_q[q_idx];
         rsp_value_q    <= bus.query_valid && q_in && valid_q[q_idx] && value_q[q_idx];
      end
   end

`ifdef SHADOW_CHECK_EN
   logic err_range_q, err_conflict_q, range_set, conf_set;

   assign range_set = !clr && ((bus.resync_valid && !r_in)
                               || (bus.assign_valid && ready && !a_in)
                               || (bus.unassign_valid && ready && !u_in));
   // Opposite-value rewrite of an assigned entry, or a live assign while syncing
   assign conf_set  = !clr && ((r_we && valid_q[r_idx] && (value_q[r_idx] != bus.resync_value))
                               || (a_we && valid_q[a_idx] && (value_q[a_idx] != bus.assign_value))
                               || (bus.assign_valid && !ready));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_range_q    <= 1'b0;
         err_conflict_q <= 1'b0;
      end else begin
         err_range_q    <= !clr && (err_range_q || range_set);
         err_conflict_q <= !clr && (err_conflict_q || conf_set);
      end
   end

   assign err_any          = err_range_q || err_conflict_q;
   assign bus.err_range    = err_range_q;
   assign bus.err_conflict = err_conflict_q;
`else
   assign err_any          = 1'b0;
   assign bus.err_range    = 1'b0;
   assign bus.err_conflict = 1'b0;
`endif

   assign bus.assigned_count     = cnt_q;
   assign bus.syncing            = syncing_q;
   assign bus.sync_ok            = sync_ok_q;
   assign bus.sync_err           = sync_err_q;
   assign bus.query_rsp_valid    = rsp_valid_q;
   assign bus.query_rsp_assigned = rsp_assigned_q;
   assign bus.query_rsp_value    = rsp_value_q;
endmodule

// File: doc/shadow_assign_table.md
# shadow_assign_table

Per-variable shadow assignment store sitting directly downstream of the trail resync stage. It consumes the clear pulse and the one-per-cycle resync assignment stream, plus live assign/unassign updates from the propagate-search engine during normal search. It answers single-variable "is X assigned, to what" queries for the PSE/VDE. At the end of each resync it checks that the rebuilt shadow state matches the trail height.

## Interface
- NUM_VARS, 1024, number of tracked variables; legal indices 0..NUM_VARS-1.
- CNT_W, $clog2(NUM_VARS)+1, width of the assigned-variable counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear_shadows  in  1  pulse; invalidates every entry.
- resync_valid  in  1  pulse; one resync assignment this cycle; no backpressure.
- resync_var  in  32  resync variable index.
- resync_value  in  1  resync assigned value.
- resync_done  in  1  pulse; replay complete.
- trail_height  in  16  expected assigned count, sampled on resync_done.
- assign_valid / assign_var[31:0] / assign_value  in  1/32/1  live assignment from PSE.
- unassign_valid / unassign_var[31:0]  in  1/32  live unassignment (backtrack).
- query_valid / query_var[31:0]  in  1/32  lookup request.
- query_rsp_valid  out  1  lookup response strobe.
- query_rsp_assigned  out  1  entry is assigned.
- query_rsp_value  out  1  assigned value (0 when unassigned).
- assigned_count  out  CNT_W  number of assigned entries.
- syncing  out  1  high from clear until the check completes.
- sync_ok  out  1  pulse; check passed.
- sync_err  out  1  pulse; check failed.
- err_range  out  1  sticky; an out-of-range index was seen; cleared by clear_shadows.
- err_conflict  out  1  sticky; a write hit an assigned entry; cleared by clear_shadows.

## Operation
- Storage: per-variable valid bit and value bit, held in flops. clear_shadows zeroes all valid bits and assigned_count in one cycle.
- FSM states:
  - READY: clear_shadows -> SYNC.
  - SYNC: resync_done -> CHECK. clear_shadows restarts SYNC (re-clears).
  - CHECK: one cycle, then -> READY.
- syncing = (state != READY).
- Resync write (any state; warned in READY only via err flags):
  - Index >= NUM_VARS: dropped, err_range set.
  - Target unassigned: set valid, store value, assigned_count+1.
  - Target assigned, same value: no change (duplicate).
  - Target assigned, opposite value: value overwritten, count unchanged, err_conflict set.
- Assign: same rules as a resync write, accepted only in READY. In SYNC/CHECK it is dropped and err_conflict is set.
- Unassign: accepted only in READY.
  - Target assigned: clear valid, assigned_count-1.
  - Target unassigned: no change.
  - Out of range: err_range set.
- Same-cycle priority: clear_shadows > resync write > assign > unassign.
  - Writes losing to clear are dropped silently.
  - Assign and unassign to the same var in one cycle: assign wins, unassign dropped.
  - Assign and unassign to different vars in one cycle: both applied, count net 0.
- CHECK: sync_ok = (assigned_count == trail_height latched at resync_done) && !err_range && !err_conflict. Otherwise sync_err.
- resync_done outside SYNC: ignored.

## Timing
- Reset: state READY, all valid bits 0, assigned_count 0. syncing, sync_ok, sync_err, err_range, err_conflict, query_rsp_* all 0.
- Updates take effect at the clock edge. Count and flags are visible the following cycle.
- Query: registered, 1-cycle latency. Back-to-back queries give one response per cycle.
- Query in the same cycle as a write/clear returns the pre-write state (read-before-write).
- resync_valid on the cycle right after clear_shadows is accepted; replay has no gap.
- resync_done -> CHECK next cycle -> sync_ok/sync_err pulse for exactly that one cycle -> READY.
- Index compare uses all 32 bits (no truncation).
- assigned_count never exceeds NUM_VARS or goes below 0 by construction.

## Configuration
- SHADOW_CHECK_EN defined: duplicate/conflict/range detection, err_* flags, and the CHECK error terms are as above.
- Not defined:
  - err_range and err_conflict are tied 0.
  - Out-of-range writes are still dropped.
  - Opposite-value writes silently overwrite.
  - Assign/unassign during SYNC is still dropped.
  - sync_ok depends only on the count compare.

## Test plan
- Reset, then query var 5 -> rsp_valid next cycle, assigned=0, value=0. assigned_count=0.
- clear; resync (3,1),(7,0),(9,1) back-to-back; resync_done with trail_height=3 -> sync_ok pulse 2 cycles after done, count=3, query 7 returns assigned=1, value=0.
- Same as previous but trail_height=4 -> sync_err pulse, sync_ok stays 0.
- In SYNC, resync (3,1) then (3,0) -> err_conflict=1, count=1, sync_err at check. A later clear drops err_conflict to 0.
- In READY, assign (2000,1) with NUM_VARS=1024 -> dropped, err_range=1, count unchanged.
- In READY, assign (4,1) and unassign 4 in the same cycle -> var 4 assigned, count+1. Clear plus resync in the same cycle -> write dropped, count=0.
